d_control_pipe: RTL and testbench

- Parametrised successor to the decode-stage control generator of the 5-stage MIPS core.
- Decodes the opcode of the instruction in ID into the control bundle and pipelines that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Adds what the combinational decoder lacks: branch decode, illegal-opcode flag, load-use hazard detection with bubble insertion, flush, and a global hold.

---
 rtl/d_control_pipe_if.sv | 41 ++++
 rtl/d_control_pipe.sv | 163 ++++++++++++++++
 tb/tb_d_control_pipe.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/d_control_pipe_if.sv
// Bundle between the ID-stage instruction source and the control pipeline.
// The master drives the instruction and the flush/hold controls; the slave returns the per-stage control signals.
interface d_control_pipe_if #(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OTHER_W    = 4
);
    logic [INSTR_W-1:0]    i_con_instru;
    logic                  i_flush;
    logic                  i_hold;
    logic                  o_stall;
    logic                  o_ex_regdst;
    logic                  o_ex_alusrc;
    logic                  o_ex_branch;
    logic                  o_ex_bne;
    logic                  o_ex_illegal;
    logic [1:0]            o_ex_aluop;
    logic [OTHER_W-1:0]    o_ex_other;
    logic [REG_ADDR_W-1:0] o_ex_rs;
    logic [REG_ADDR_W-1:0] o_ex_rt;
    logic [REG_ADDR_W-1:0] o_ex_dest;
    logic                  o_mem_memread;
    logic                  o_mem_memwrite;
    logic                  o_wb_regwrite;
    logic                  o_wb_memtoreg;
    logic [REG_ADDR_W-1:0] o_wb_dest;

    modport master (
        output i_con_instru, i_flush, i_hold,
        input  o_stall, o_ex_regdst, o_ex_alusrc, o_ex_branch, o_ex_bne, o_ex_illegal,
               o_ex_aluop, o_ex_other, o_ex_rs, o_ex_rt, o_ex_dest,
               o_mem_memread, o_mem_memwrite, o_wb_regwrite, o_wb_memtoreg, o_wb_dest
    );

    modport slave (
        input  i_con_instru, i_flush, i_hold,
        output o_stall, o_ex_regdst, o_ex_alusrc, o_ex_branch, o_ex_bne, o_ex_illegal,
               o_ex_aluop, o_ex_other, o_ex_rs, o_ex_rt, o_ex_dest,
               o_mem_memread, o_mem_memwrite, o_wb_regwrite, o_wb_memtoreg, o_wb_dest
    );
endinterface

// File: rtl/d_control_pipe.sv
// ID-stage control decoder with ID/EX, EX/MEM and MEM/WB control registers,
// load-use bubble insertion, flush and global hold.
module d_control_pipe #(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OTHER_W    = 4,
    parameter int HAZARD_EN  = 1
) (
    input logic             i_clk,
    input logic             i_rst,
    d_control_pipe_if.slave bus
);
    typedef struct packed {
        logic               regdst;
        logic               alusrc;
        logic               branch;
        logic               bne;
        logic               illegal;
        logic [1:0]         aluop;
        logic [OTHER_W-1:0] other;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        casez (op)
            6'b000000: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = 2'b10;
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.aluop    = 2'b11;
                case (op[2:0])
                    3'b100:  c.other = OTHER_W'(4'd1);
                    3'b101:  c.other = OTHER_W'(4'd2);
                    3'b110:  c.other = OTHER_W'(4'd3);
                    3'b010:  c.other = OTHER_W'(4'd6);
                    default: c.other = '0;
                endcase
            end
            6'b100???: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
            end
            6'b101???: begin
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            6'b000100: begin
                c.branch = 1'b1;
                c.aluop  = 2'b01;
            end
            6'b000101: begin
                c.branch = 1'b1;
                c.bne    = 1'b1;
                c.aluop  = 2'b01;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Opcodes whose rt field is a source operand (R-type, stores, branches).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == 6'b000000) || (op[5:3] == 3'b101) ||
               (op == 6'b000100) || (op == 6'b000101);
    endfunction

    logic [5:0]            dec_op;
    logic [REG_ADDR_W-1:0] dec_rs, dec_rt, dec_rd, dec_dest;
    ctrl_t                 dec;
    logic                  hz;
    logic                  unused_bits;

    ctrl_t                 ctrl_p0;
    logic [REG_ADDR_W-1:0] rs_p0, rt_p0, dest_p0;
    logic                  memread_p1, memwrite_p1, regwrite_p1, memtoreg_p1;
    logic [REG_ADDR_W-1:0] dest_p1;
    logic                  regwrite_p2, memtoreg_p2;
    logic [REG_ADDR_W-1:0] dest_p2;

    assign dec_op      = bus.i_con_instru[INSTR_W-1 -: 6];
    assign dec_rs      = bus.i_con_instru[25 -: REG_ADDR_W];
    assign dec_rt      = bus.i_con_instru[20 -: REG_ADDR_W];
    assign dec_rd      = bus.i_con_instru[15 -: REG_ADDR_W];
    assign unused_bits = ^bus.i_con_instru[10:0];

    always_comb begin
        dec      = decode(dec_op);
        dec_dest = '0;
        if (dec.regwrite)
            dec_dest = dec.regdst ? dec_rd : dec_rt;
    end

    assign hz = (HAZARD_EN != 0) && ctrl_p0.memread && (rt_p0 != '0) &&
                ((rt_p0 == dec_rs) || ((rt_p0 == dec_rt) && reads_rt(dec_op)));
    assign bus.o_stall = hz & ~bus.i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_p0     <= '0;
            rs_p0       <= '0;
            rt_p0       <= '0;
            dest_p0     <= '0;
            memread_p1  <= 1'b0;
            memwrite_p1 <= 1'b0;
            regwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
            dest_p1     <= '0;
            regwrite_p2 <= 1'b0;
            memtoreg_p2 <= 1'b0;
            dest_p2     <= '0;
        end else if (!bus.i_hold) begin
            // MEM/WB
            regwrite_p2 <= regwrite_p1;
            memtoreg_p2 <= memtoreg_p1;
            dest_p2     <= dest_p1;
            // EX/MEM
            memread_p1  <= ctrl_p0.memread;
            memwrite_p1 <= ctrl_p0.memwrite;
            regwrite_p1 <= ctrl_p0.regwrite;
            memtoreg_p1 <= ctrl_p0.memtoreg;
            dest_p1     <= dest_p0;
            // ID/EX: a squashed or stalled slot becomes an all-zero NOP
            if (bus.i_flush || hz) begin
                ctrl_p0 <= '0;
                rs_p0   <= '0;
                rt_p0   <= '0;
                dest_p0 <= '0;
            end else begin
                ctrl_p0 <= dec;
                rs_p0   <= dec_rs;
                rt_p0   <= dec_rt;
                dest_p0 <= dec_dest;
            end
        end
    end

    assign bus.o_ex_regdst    = ctrl_p0.regdst;
    assign bus.o_ex_alusrc    = ctrl_p0.alusrc;
    assign bus.o_ex_branch    = ctrl_p0.branch;
    assign bus.o_ex_bne       = ctrl_p0.bne;
    assign bus.o_ex_illegal   = ctrl_p0.illegal;
    assign bus.o_ex_aluop     = ctrl_p0.aluop;
    assign bus.o_ex_other     = ctrl_p0.other;
    assign bus.o_ex_rs        = rs_p0;
    assign bus.o_ex_rt        = rt_p0;
    assign bus.o_ex_dest      = dest_p0;
    assign bus.o_mem_memread  = memread_p1;
    assign bus.o_mem_memwrite = memwrite_p1;
    assign bus.o_wb_regwrite  = regwrite_p2;
    assign bus.o_wb_memtoreg  = memtoreg_p2;
    assign bus.o_wb_dest      = dest_p2;
endmodule

// File: tb/tb_d_control_pipe.sv
// Scoreboard bench for d_control_pipe: directed program segments plus random traffic, checked
// against an instruction-level pipeline model, for HAZARD_EN=1 and HAZARD_EN=0 instances.
module tb_d_control_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    d_control_pipe_if bus ();
    d_control_pipe_if bus_nh ();

    d_control_pipe #(.HAZARD_EN(1)) u_dut    (.i_clk(clk), .i_rst(rst), .bus(bus));
    d_control_pipe #(.HAZARD_EN(0)) u_dut_nh (.i_clk(clk), .i_rst(rst), .bus(bus_nh));

    assign bus_nh.i_con_instru = bus.i_con_instru;
    assign bus_nh.i_flush      = bus.i_flush;
    assign bus_nh.i_hold       = bus.i_hold;

    typedef struct packed {
        logic       regdst, alusrc, branch, bne, illegal;
        logic [1:0] aluop;
        logic [3:0] other;
        logic       memread, memwrite, regwrite, memtoreg;
        logic [4:0] rs, rt, dest;
    } rec_t;

    typedef struct packed { rec_t ex, mem, wb; } pipe_t;

    typedef struct packed {
        logic  chk;
        logic  stall;
        pipe_t p;
        logic  stall_nh;
        pipe_t pnh;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] iq[$];
    logic [31:0] cur;
    pipe_t       mp, mpn;
    logic        known;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [31:0] NOP = 32'h0;

    function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd);
        logic [5:0] o;
        logic [4:0] s, t, d;
        o = op[5:0]; s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
        return {o, s, t, d, 11'h0};
    endfunction

    // Instruction-level meaning of each opcode class
    function automatic rec_t ref_decode(input logic [31:0] ins);
        rec_t r;
        int   op;
        r  = '0;
        op = int'(ins[31:26]);
        if (op == 0) begin
            r.regdst = 1; r.regwrite = 1; r.aluop = 2'd2;
        end else if (op == 8 || op == 9 || op == 12 || op == 13 || op == 14 || op == 10) begin
            r.regwrite = 1; r.alusrc = 1; r.aluop = 2'd3;
            r.other = (op == 12) ? 4'd1 : (op == 13) ? 4'd2 : (op == 14) ? 4'd3 :
                      (op == 10) ? 4'd6 : 4'd0;
        end else if (op >= 32 && op <= 39) begin
            r.regwrite = 1; r.alusrc = 1; r.memread = 1; r.memtoreg = 1;
        end else if (op >= 40 && op <= 47) begin
            r.alusrc = 1; r.memwrite = 1;
        end else if (op == 4) begin
            r.branch = 1; r.aluop = 2'd1;
        end else if (op == 5) begin
            r.branch = 1; r.bne = 1; r.aluop = 2'd1;
        end else begin
            r.illegal = 1;
        end
        r.rs   = ins[25:21];
        r.rt   = ins[20:16];
        r.dest = !r.regwrite ? 5'd0 : (r.regdst ? ins[15:11] : ins[20:16]);
        return r;
    endfunction

    function automatic logic uses_rt(input logic [31:0] ins);
        int op;
        op = int'(ins[31:26]);
        return op == 0 || (op >= 40 && op <= 47) || op == 4 || op == 5;
    endfunction

    function automatic pipe_t pipe_next(input pipe_t p, input logic [31:0] ins, input logic r,
                                        input logic fl, input logic hd, input logic hz_en,
                                        output logic stall);
        rec_t  d;
        logic  hz;
        pipe_t n;
        d     = ref_decode(ins);
        hz    = hz_en && p.ex.memread && p.ex.rt != 5'd0 &&
                (p.ex.rt == d.rs || (p.ex.rt == d.rt && uses_rt(ins)));
        stall = hz && !fl;
        n     = p;
        if (r) n = '0;
        else if (!hd) begin
            n.wb  = p.mem;
            n.mem = p.ex;
            n.ex  = (fl || hz) ? '0 : d;
        end
        return n;
    endfunction

    function automatic logic [25:0] ex_vec(input rec_t r);
        return {r.regdst, r.alusrc, r.branch, r.bne, r.illegal, r.aluop, r.other, r.rs, r.rt, r.dest};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the instruction in ID advances unless stalled, held or in reset
    task automatic cycle(input logic r, input logic fl, input logic hd);
        exp_t e;
        logic s, snh;
        @(negedge clk);
        rst              = r;
        bus.i_flush      = fl;
        bus.i_hold       = hd;
        bus.i_con_instru = cur;
        e.chk      = known;
        mp         = pipe_next(mp, cur, r, fl, hd, 1'b1, s);
        mpn        = pipe_next(mpn, cur, r, fl, hd, 1'b0, snh);
        e.stall    = s;
        e.p        = mp;
        e.stall_nh = snh;
        e.pnh      = mpn;
        sbq.push_back(e);
        if (r) known = 1'b1;
        if (!r && !hd && !s) begin
            if (iq.size() > 0) cur = iq.pop_front();
            else cur = NOP;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk) begin
                    chk("stall", 32'(bus.o_stall), 32'(e.stall));
                    chk("stall_nh", 32'(bus_nh.o_stall), 32'(e.stall_nh));
                end
                @(posedge clk);
                #1;
                chk("ex", 32'({bus.o_ex_regdst, bus.o_ex_alusrc, bus.o_ex_branch, bus.o_ex_bne,
                               bus.o_ex_illegal, bus.o_ex_aluop, bus.o_ex_other, bus.o_ex_rs,
                               bus.o_ex_rt, bus.o_ex_dest}), 32'(ex_vec(e.p.ex)));
                chk("mem", 32'({bus.o_mem_memread, bus.o_mem_memwrite}),
                    32'({e.p.mem.memread, e.p.mem.memwrite}));
                chk("wb", 32'({bus.o_wb_regwrite, bus.o_wb_memtoreg, bus.o_wb_dest}),
                    32'({e.p.wb.regwrite, e.p.wb.memtoreg, e.p.wb.dest}));
                chk("ex_nh", 32'({bus_nh.o_ex_regdst, bus_nh.o_ex_alusrc, bus_nh.o_ex_branch,
                                  bus_nh.o_ex_bne, bus_nh.o_ex_illegal, bus_nh.o_ex_aluop,
                                  bus_nh.o_ex_other, bus_nh.o_ex_rs, bus_nh.o_ex_rt,
                                  bus_nh.o_ex_dest}), 32'(ex_vec(e.pnh.ex)));
                chk("mem_nh", 32'({bus_nh.o_mem_memread, bus_nh.o_mem_memwrite}),
                    32'({e.pnh.mem.memread, e.pnh.mem.memwrite}));
                chk("wb_nh", 32'({bus_nh.o_wb_regwrite, bus_nh.o_wb_memtoreg, bus_nh.o_wb_dest}),
                    32'({e.pnh.wb.regwrite, e.pnh.wb.memtoreg, e.pnh.wb.dest}));
            end
        end
    end

    int ops[16] = '{0, 8, 9, 12, 13, 14, 10, 35, 32, 43, 40, 4, 5, 63, 2, 15};

    initial begin : stimulus
        rst              = 1'b1;
        bus.i_flush      = 1'b0;
        bus.i_hold       = 1'b0;
        bus.i_con_instru = '0;
        known            = 1'b0;
        mp               = '0;
        mpn              = '0;
        cur              = mk(8, 0, 9, 0);

        // Reset with ADDI present, then straight-line flow
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        iq.push_back(mk(13, 2, 9, 0));
        iq.push_back(mk(0, 1, 2, 12));
        // Load-use with a real and with a $0 destination
        iq.push_back(mk(35, 1, 8, 0));
        iq.push_back(mk(0, 8, 2, 3));
        iq.push_back(mk(35, 1, 0, 0));
        iq.push_back(mk(0, 0, 2, 3));
        // Store consumer stalls, immediate writer does not
        iq.push_back(mk(35, 1, 5, 0));
        iq.push_back(mk(43, 2, 5, 0));
        iq.push_back(mk(35, 1, 5, 0));
        iq.push_back(mk(8, 3, 5, 0));
        // Branch and illegal opcode
        iq.push_back(mk(5, 1, 2, 0));
        iq.push_back(mk(63, 1, 2, 3));
        repeat (20) cycle(0, 0, 0);

        // Flush while the hazard is pending
        iq.push_back(mk(35, 1, 8, 0));
        iq.push_back(mk(0, 8, 2, 3));
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (4) cycle(0, 0, 0);

        // Three-cycle hold mid-stream
        for (int i = 1; i <= 4; i++) iq.push_back(mk(8, 0, i, 0));
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        repeat (3) cycle(0, 0, 1);
        repeat (6) cycle(0, 0, 0);

        // Reset with instructions in flight
        iq.push_back(mk(35, 1, 6, 0));
        iq.push_back(mk(0, 1, 2, 7));
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (4) cycle(0, 0, 0);

        // Random traffic with small register numbers to provoke hazards
        for (int n = 0; n < 600; n++) begin
            if (iq.size() < 2)
                iq.push_back(mk(ops[$urandom_range(0, 15)], $urandom_range(0, 7),
                                $urandom_range(0, 7), $urandom_range(0, 31)));
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 10);
        end
        repeat (4) cycle(0, 0, 0);

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
